ajuste_reloj: RTL and testbench

Button-driven time-setting controller that drives the adjust side of the hours/minutes clock counter. It captures the running time, lets the user edit hour, tens-of-minutes and units-of-minutes in turn with two push-buttons, then holds a load strobe with the edited values for the counter to take. It sits between the board buttons and the clock counter's adjust inputs. It also exposes the field being edited so the display driver can blink it.

---
 rtl/ajuste_pkg.sv | 59 +++++
 rtl/antirrebote.sv | 51 +++++
 rtl/ajuste_reloj.sv | 174 +++++++++++++++++
 tb/tb_ajuste_reloj.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ajuste_pkg.sv
// ajuste_pkg: shared types and constants for the time-setting controller.
//   estado_t      - controller states (IDLE, ED_HORA, ED_DMIN, ED_UMIN, LOAD)
//   CAMPO_*       - encodings of the field-under-edit output
//   HORA_MIN/MAX, DMIN_MAX, UMIN_MAX - legal field limits
//   edicion_t     - packed hour/tens/units payload held by the edit registers
package ajuste_pkg;

    localparam int unsigned DIGITO_W = 4;
    localparam int unsigned CAMPO_W  = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ED_HORA = 3'd1,
        ED_DMIN = 3'd2,
        ED_UMIN = 3'd3,
        LOAD    = 3'd4
    } estado_t;

    localparam logic [CAMPO_W-1:0] CAMPO_NINGUNO = 2'b00;
    localparam logic [CAMPO_W-1:0] CAMPO_HORA    = 2'b01;
    localparam logic [CAMPO_W-1:0] CAMPO_DMIN    = 2'b10;
    localparam logic [CAMPO_W-1:0] CAMPO_UMIN    = 2'b11;

    localparam logic [DIGITO_W-1:0] HORA_MIN = 4'd1;
    localparam logic [DIGITO_W-1:0] HORA_MAX = 4'd12;
    localparam logic [DIGITO_W-1:0] DMIN_MAX = 4'd5;
    localparam logic [DIGITO_W-1:0] UMIN_MAX = 4'd9;

    typedef struct packed {
        logic [DIGITO_W-1:0] hora;
        logic [DIGITO_W-1:0] dmin;
        logic [DIGITO_W-1:0] umin;
    } edicion_t;

    localparam edicion_t EDICION_RESET = '{hora: HORA_MIN, dmin: 4'd0, umin: 4'd0};

    // Capture of the running time; out-of-range fields fall back to their minimum.
    function automatic edicion_t captura(input logic [DIGITO_W-1:0] h,
                                         input logic [DIGITO_W-1:0] d,
                                         input logic [DIGITO_W-1:0] u);
        edicion_t r;
        r.hora = ((h >= HORA_MIN) && (h <= HORA_MAX)) ? h : HORA_MIN;
        r.dmin = (d <= DMIN_MAX) ? d : 4'd0;
        r.umin = (u <= UMIN_MAX) ? u : 4'd0;
        return r;
    endfunction

    // Hour advance 1..12 with wrap back to 1.
    function automatic logic [DIGITO_W-1:0] sig_hora(input logic [DIGITO_W-1:0] h);
        return (h == HORA_MAX) ? HORA_MIN : h + 4'd1;
    endfunction

    // Digit advance 0..max with wrap back to 0.
    function automatic logic [DIGITO_W-1:0] sig_digito(input logic [DIGITO_W-1:0] v,
                                                       input logic [DIGITO_W-1:0] max);
        return (v == max) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote: 2-FF synchronizer, debouncer and rising-edge press pulse for one button.
//   clock, reset_n - clock and asynchronous active-low reset
//   boton          - raw asynchronous active-high button
//   pulso          - one-cycle pulse on each accepted 0->1 transition
// A new level is accepted only after DEBOUNCE_CYCLES consecutive samples that
// differ from the current accepted level.
module antirrebote #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic boton,
    output logic pulso
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             estable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulso_q;
    logic             cambio_c;
    logic             aceptar_c;

    assign cambio_c  = sync_q[1] != estable_q;
    assign aceptar_c = cambio_c && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchronizer, stability counter and edge pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b00;
            estable_q <= 1'b0;
            cnt_q     <= '0;
            pulso_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], boton};
            pulso_q <= aceptar_c && sync_q[1];
            if (!cambio_c) begin
                cnt_q <= '0;
            end else if (aceptar_c) begin
                cnt_q     <= '0;
                estable_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/ajuste_reloj.sv
// ajuste_reloj: button-driven time-setting controller for the hh:mm clock counter.
//   clock, reset_n               - clock and asynchronous active-low reset
//   btn_modo, btn_inc            - raw mode / increment buttons
//   hora/dmin/umin_actual        - running time captured when editing starts
//   ajust_en                     - load strobe, high LOAD_CYCLES cycles
//   ajust_hora/dmin/umin         - edited values (edit registers)
//   campo                        - field under edit, for display blinking
// Optional: define AJUSTE_TIMEOUT_EN to abandon an edit after TIMEOUT_CYCLES
// cycles without any press.
module ajuste_reloj
    import ajuste_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LOAD_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                btn_modo,
    input  logic                btn_inc,
    input  logic [DIGITO_W-1:0] hora_actual,
    input  logic [DIGITO_W-1:0] dmin_actual,
    input  logic [DIGITO_W-1:0] umin_actual,
    output logic                ajust_en,
    output logic [DIGITO_W-1:0] ajust_hora,
    output logic [DIGITO_W-1:0] ajust_dmin,
    output logic [DIGITO_W-1:0] ajust_umin,
    output logic [CAMPO_W-1:0]  campo
);

    localparam int unsigned LOAD_W = $clog2(LOAD_CYCLES + 1);

    logic p_modo;
    logic p_inc;

    estado_t              estado_q,   estado_d;
    edicion_t             edicion_q,  edicion_d;
    logic [CAMPO_W-1:0]   campo_q,    campo_d;
    logic                 en_q,       en_d;
    logic [LOAD_W-1:0]    cnt_load_q, cnt_load_d;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_modo (
        .clock   (clock),
        .reset_n (reset_n),
        .boton   (btn_modo),
        .pulso   (p_modo)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_inc (
        .clock   (clock),
        .reset_n (reset_n),
        .boton   (btn_inc),
        .pulso   (p_inc)
    );

`ifdef AJUSTE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] cnt_to_q, cnt_to_d;
    logic            en_edicion_c;

    assign en_edicion_c = (estado_q == ED_HORA) || (estado_q == ED_DMIN) ||
                          (estado_q == ED_UMIN);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= IDLE;
            edicion_q  <= EDICION_RESET;
            campo_q    <= CAMPO_NINGUNO;
            en_q       <= 1'b0;
            cnt_load_q <= '0;
`ifdef AJUSTE_TIMEOUT_EN
            cnt_to_q   <= '0;
`endif
        end else begin
            estado_q   <= estado_d;
            edicion_q  <= edicion_d;
            campo_q    <= campo_d;
            en_q       <= en_d;
            cnt_load_q <= cnt_load_d;
`ifdef AJUSTE_TIMEOUT_EN
            cnt_to_q   <= cnt_to_d;
`endif
        end
    end

    // Next state, next edit values and next registered outputs.
    // A modo press is checked before inc, so a simultaneous inc is dropped.
    always_comb begin
        estado_d   = estado_q;
        edicion_d  = edicion_q;
        campo_d    = campo_q;
        en_d       = 1'b0;
        cnt_load_d = cnt_load_q;
`ifdef AJUSTE_TIMEOUT_EN
        cnt_to_d   = '0;
`endif

        case (estado_q)
            IDLE: begin
                campo_d = CAMPO_NINGUNO;
                if (p_modo) begin
                    edicion_d = captura(hora_actual, dmin_actual, umin_actual);
                    estado_d  = ED_HORA;
                    campo_d   = CAMPO_HORA;
                end
            end
            ED_HORA: begin
                if (p_modo) begin
                    estado_d = ED_DMIN;
                    campo_d  = CAMPO_DMIN;
                end else if (p_inc) begin
                    edicion_d.hora = sig_hora(edicion_q.hora);
                end
            end
            ED_DMIN: begin
                if (p_modo) begin
                    estado_d = ED_UMIN;
                    campo_d  = CAMPO_UMIN;
                end else if (p_inc) begin
                    edicion_d.dmin = sig_digito(edicion_q.dmin, DMIN_MAX);
                end
            end
            ED_UMIN: begin
                if (p_modo) begin
                    estado_d   = LOAD;
                    campo_d    = CAMPO_NINGUNO;
                    en_d       = 1'b1;
                    cnt_load_d = '0;
                end else if (p_inc) begin
                    edicion_d.umin = sig_digito(edicion_q.umin, UMIN_MAX);
                end
            end
            LOAD: begin
                campo_d = CAMPO_NINGUNO;
                // The entry cycle already counts as the first strobe cycle.
                if (cnt_load_q == LOAD_W'(LOAD_CYCLES - 1)) begin
                    estado_d   = IDLE;
                    cnt_load_d = '0;
                end else begin
                    en_d       = 1'b1;
                    cnt_load_d = cnt_load_q + LOAD_W'(1);
                end
            end
            default: begin
                estado_d = IDLE;
                campo_d  = CAMPO_NINGUNO;
            end
        endcase

`ifdef AJUSTE_TIMEOUT_EN
        // Idle counter while editing; any press restarts it.
        if (en_edicion_c && !(p_modo || p_inc)) begin
            if (cnt_to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                estado_d = IDLE;
                campo_d  = CAMPO_NINGUNO;
            end else begin
                cnt_to_d = cnt_to_q + TO_W'(1);
            end
        end
`endif
    end

    assign ajust_en   = en_q;
    assign ajust_hora = edicion_q.hora;
    assign ajust_dmin = edicion_q.dmin;
    assign ajust_umin = edicion_q.umin;
    assign campo      = campo_q;

endmodule

// File: tb/tb_ajuste_reloj.sv
// tb_ajuste_reloj: randomized self-checking bench for ajuste_reloj against a
// field-level reference model (field index plus modular digit arithmetic).
module tb_ajuste_reloj;

    localparam int unsigned DB = 4;
    localparam int unsigned LC = 4;
    localparam int unsigned TO = 200;
    localparam int unsigned SETTLE = DB + 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_modo;
    logic       btn_inc;
    logic [3:0] hora_actual;
    logic [3:0] dmin_actual;
    logic [3:0] umin_actual;
    logic       ajust_en;
    logic [3:0] ajust_hora;
    logic [3:0] ajust_dmin;
    logic [3:0] ajust_umin;
    logic [1:0] campo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: field index (0 none, 1 hora, 2 dmin, 3 umin) and values.
    int m_f;
    int m_h;
    int m_d;
    int m_u;

    always #5 clock = ~clock;

    ajuste_reloj #(
        .DEBOUNCE_CYCLES (DB),
        .LOAD_CYCLES     (LC),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .btn_modo    (btn_modo),
        .btn_inc     (btn_inc),
        .hora_actual (hora_actual),
        .dmin_actual (dmin_actual),
        .umin_actual (umin_actual),
        .ajust_en    (ajust_en),
        .ajust_hora  (ajust_hora),
        .ajust_dmin  (ajust_dmin),
        .ajust_umin  (ajust_umin),
        .campo       (campo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic model_reset();
        m_f = 0; m_h = 1; m_d = 0; m_u = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".campo"}, 32'(campo), 32'(m_f));
        chk({tag, ".hora"},  32'(ajust_hora), 32'(m_h));
        chk({tag, ".dmin"},  32'(ajust_dmin), 32'(m_d));
        chk({tag, ".umin"},  32'(ajust_umin), 32'(m_u));
        chk({tag, ".en"},    32'(ajust_en), 32'd0);
    endtask

    // Model reaction to one press event (modo wins over inc).
    task automatic model_press(input bit modo, input bit inc);
        int a;
        if (modo) begin
            if (m_f == 0) begin
                a = int'(hora_actual);
                m_h = (a >= 1 && a <= 12) ? a : 1;
                a = int'(dmin_actual);
                m_d = (a <= 5) ? a : 0;
                a = int'(umin_actual);
                m_u = (a <= 9) ? a : 0;
                m_f = 1;
            end else if (m_f < 3) begin
                m_f = m_f + 1;
            end else begin
                m_f = 0;
            end
        end else if (inc) begin
            case (m_f)
                1: m_h = (m_h % 12) + 1;
                2: m_d = (m_d + 1) % 6;
                3: m_u = (m_u + 1) % 10;
                default: ;
            endcase
        end
    endtask

    // modo press from umin: strobe must last LC cycles with steady values.
    task automatic press_load(input string tag);
        int en_cnt;
        int rises;
        int steady;
        logic prev;
        en_cnt = 0; rises = 0; steady = 1; prev = 1'b0;
        btn_modo = 1'b1;
        for (int i = 0; i < int'(2 * SETTLE); i++) begin
            if (i == int'(SETTLE)) btn_modo = 1'b0;
            tick(1);
            if (ajust_en === 1'b1) begin
                en_cnt++;
                if (!prev) rises++;
                if (int'(ajust_hora) != m_h || int'(ajust_dmin) != m_d ||
                    int'(ajust_umin) != m_u) steady = 0;
            end
            prev = ajust_en;
        end
        chk({tag, ".load_len"},    32'(en_cnt), 32'(LC));
        chk({tag, ".load_pulses"}, 32'(rises), 32'd1);
        chk({tag, ".load_steady"}, 32'(steady), 32'd1);
        model_press(1'b1, 1'b0);
        check_outputs({tag, ".after_load"});
    endtask

    // Clean press: hold, release, then compare against the model.
    task automatic press(input string tag, input bit modo, input bit inc);
        if (modo && m_f == 3) begin
            press_load(tag);
        end else begin
            btn_modo = modo;
            btn_inc  = inc;
            tick(SETTLE);
            btn_modo = 1'b0;
            btn_inc  = 1'b0;
            tick(SETTLE);
            model_press(modo, inc);
            check_outputs(tag);
        end
    endtask

    task automatic set_actual(input int h, input int d, input int u);
        hora_actual = 4'(h);
        dmin_actual = 4'(d);
        umin_actual = 4'(u);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int r;
        reset_n  = 1'b0;
        btn_modo = 1'b0;
        btn_inc  = 1'b0;
        set_actual(0, 0, 0);
        model_reset();
        tick(3);
        check_outputs("in_reset");
        reset_n = 1'b1;
        tick(2);
        check_outputs("post_reset");

        // Capture and hour wrap.
        set_actual(11, 4, 7);
        press("cap_11_4_7", 1'b1, 1'b0);
        press("hora_to_12", 1'b0, 1'b1);
        chk("hora_is_12", 32'(ajust_hora), 32'd12);
        press("hora_to_1", 1'b0, 1'b1);
        chk("hora_is_1", 32'(ajust_hora), 32'd1);
        press("to_dmin", 1'b1, 1'b0);
        press("to_umin", 1'b1, 1'b0);
        press("load_a", 1'b1, 1'b0);

        // Full path with dmin and umin wrap.
        set_actual(3, 5, 9);
        press("cap_3_5_9", 1'b1, 1'b0);
        press("fp_dmin", 1'b1, 1'b0);
        press("fp_dmin_wrap", 1'b0, 1'b1);
        press("fp_umin", 1'b1, 1'b0);
        press("fp_umin_wrap", 1'b0, 1'b1);
        press("fp_load", 1'b1, 1'b0);
        chk("fp_final_hora", 32'(ajust_hora), 32'd3);

        // Bounce on inc in ED_HORA: exactly one increment.
        set_actual(5, 2, 2);
        press("bnc_cap", 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_inc = ~btn_inc;
            tick(1);
        end
        btn_inc = 1'b1;
        tick(SETTLE);
        btn_inc = 1'b0;
        tick(SETTLE);
        model_press(1'b0, 1'b1);
        check_outputs("bounce");

        // Simultaneous presses in ED_DMIN: modo wins.
        press("sim_to_dmin", 1'b1, 1'b0);
        press("sim_both", 1'b1, 1'b1);
        press("sim_load", 1'b1, 1'b0);

        // Reset on the second cycle of LOAD.
        set_actual(7, 3, 8);
        press("rl_cap", 1'b1, 1'b0);
        press("rl_dmin", 1'b1, 1'b0);
        press("rl_umin", 1'b1, 1'b0);
        btn_modo = 1'b1;
        waited = 0;
        while (ajust_en !== 1'b1 && waited < int'(3 * SETTLE)) begin
            tick(1);
            waited++;
        end
        chk("rl_load_start", 32'(ajust_en), 32'd1);
        tick(1);
        chk("rl_load_2nd", 32'(ajust_en), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rl_async");
        btn_modo = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(SETTLE);
        check_outputs("rl_after");

        // Randomized sessions, including illegal captured values.
        for (int s = 0; s < 20; s++) begin
            set_actual(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) press("rnd_idle_inc", 1'b0, 1'b1);
            press("rnd_cap", 1'b1, 1'b0);
            for (int k = 0; k < 200 && m_f != 0; k++) begin
                r = int'($urandom_range(0, 9));
                if (r <= 5)      press("rnd_inc", 1'b0, 1'b1);
                else if (r == 6) press("rnd_both", 1'b1, 1'b1);
                else             press("rnd_modo", 1'b1, 1'b0);
            end
        end

`ifdef AJUSTE_TIMEOUT_EN
        begin
            int en_seen;
            en_seen = 0;
            set_actual(9, 1, 6);
            press("to_cap", 1'b1, 1'b0);
            press("to_dmin", 1'b1, 1'b0);
            press("to_umin", 1'b1, 1'b0);
            for (int i = 0; i < int'(TO) + 20; i++) begin
                tick(1);
                if (ajust_en === 1'b1) en_seen++;
            end
            m_f = 0;
            check_outputs("timeout");
            chk("timeout_no_en", 32'(en_seen), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
